// File: rtl/ps2_letter_rx_if.sv
// ps2_letter_rx_if: letter/event bundle from the PS/2 receiver to the game (char, char_valid, enter, frame_err, busy)
interface ps2_letter_rx_if;
  logic [4:0] char;
  logic char_valid;
  logic enter;
  logic frame_err;
  logic busy;
  modport master(output char, char_valid, enter, frame_err, busy);
  modport slave(input char, char_valid, enter, frame_err, busy);
endinterface

// File: rtl/ps2_letter_rx.sv
// ps2_letter_rx: PS/2 Set-2 receiver emitting letter codes and Enter; ports clk, resetn (async active-high), ps2_clk, ps2_dat, lt (letter bundle)
module ps2_letter_rx #(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic clk,
  input  logic resetn,
  input  logic ps2_clk,
  input  logic ps2_dat,
  ps2_letter_rx_if.master lt
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] clk_s, dat_s;
  logic clk_p, fall, bit_s, tmo, good, bad;
  logic [7:0] sh, held;
  logic [2:0] bitcnt;
  logic par, brk, ext;
  logic [WW-1:0] wd;
  function automatic logic [4:0] letter(input logic [7:0] b);
    case (b)
      8'h1C: letter = 5'd1;  8'h32: letter = 5'd2;  8'h21: letter = 5'd3;
      8'h23: letter = 5'd4;  8'h24: letter = 5'd5;  8'h2B: letter = 5'd6;
      8'h34: letter = 5'd7;  8'h33: letter = 5'd8;  8'h43: letter = 5'd9;
      8'h3B: letter = 5'd10; 8'h42: letter = 5'd11; 8'h4B: letter = 5'd12;
      8'h3A: letter = 5'd13; 8'h31: letter = 5'd14; 8'h44: letter = 5'd15;
      8'h4D: letter = 5'd16; 8'h15: letter = 5'd17; 8'h2D: letter = 5'd18;
      8'h1B: letter = 5'd19; 8'h2C: letter = 5'd20; 8'h3C: letter = 5'd21;
      8'h2A: letter = 5'd22; 8'h1D: letter = 5'd23; 8'h22: letter = 5'd24;
      8'h35: letter = 5'd25; 8'h1A: letter = 5'd26;
      default: letter = 5'd0;
    endcase
  endfunction
  assign fall = clk_p & ~clk_s[1];
  assign bit_s = dat_s[1];
  // an edge in the same cycle as the timeout takes priority
  assign tmo = (state != IDLE) && !fall && (wd == WW'(TIMEOUT_CYCLES));
  assign lt.busy = state != IDLE;
  always_comb begin
    state_n = state;
    good = 1'b0;
    bad = tmo;
    if (tmo) state_n = IDLE;
    else if (fall)
      case (state)
        IDLE: state_n = bit_s ? IDLE : DATA;
        DATA: state_n = (bitcnt == 3'd7) ? PARITY : DATA;
        PARITY: state_n = STOP;
        default: begin
          state_n = IDLE;
          good = bit_s & (^{sh, par});
          bad = ~good;
        end
      endcase
  end
  always_ff @(posedge clk or posedge resetn)
    if (resetn) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_p <= 1'b1;
      state <= IDLE;
      sh <= '0;
      bitcnt <= '0;
      par <= 1'b0;
      wd <= '0;
      brk <= 1'b0;
      ext <= 1'b0;
      held <= '0;
      lt.char <= '0;
      lt.char_valid <= 1'b0;
      lt.enter <= 1'b0;
      lt.frame_err <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_dat};
      clk_p <= clk_s[1];
      state <= state_n;
      wd <= (state == IDLE || fall) ? '0 : wd + 1'b1;
      if (fall && state == IDLE) bitcnt <= '0;
      if (fall && state == DATA) begin
        sh <= {bit_s, sh[7:1]};
        bitcnt <= bitcnt + 3'd1;
      end
      if (fall && state == PARITY) par <= bit_s;
      lt.char_valid <= 1'b0;
      lt.enter <= 1'b0;
      lt.frame_err <= bad;
      if (good) begin
        if (sh == 8'hE0) ext <= 1'b1;
        else if (sh == 8'hF0) brk <= 1'b1;
        else if (brk || ext) begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (brk) held <= '0;
        end else if (sh != held) begin
          held <= sh;
          lt.enter <= sh == 8'h5A;
          if (letter(sh) != 5'd0) begin
            lt.char <= letter(sh);
            lt.char_valid <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_ps2_letter_rx.sv
// tb_ps2_letter_rx: scoreboard bench driving PS/2 frames and checking letter/enter/error events
module tb_ps2_letter_rx;
  localparam int TMO = 100;
  localparam int H = 10;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  logic [7:0] obs;
  ps2_letter_rx_if lt();
  ps2_letter_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .lt(lt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic send_bit(input logic b);
    ps2_dat = b;
    tick(H);
    ps2_clk = 1'b0;
    tick(H);
    ps2_clk = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input logic pflip = 1'b0, input logic stop = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ pflip);
    send_bit(stop);
    ps2_dat = 1'b1;
    tick(H);
  endtask
  task automatic exp_char(input logic [4:0] c);
    q.push_back({3'd1, c});
  endtask
  task automatic exp_enter();
    q.push_back({3'd2, 5'd0});
  endtask
  task automatic exp_err();
    q.push_back({3'd3, 5'd0});
  endtask
  always @(negedge clk)
    if (!resetn && (lt.char_valid || lt.enter || lt.frame_err)) begin
      obs = lt.char_valid ? {3'd1, lt.char} : lt.enter ? {3'd2, 5'd0} : {3'd3, 5'd0};
      chk("onehot", int'(lt.char_valid) + int'(lt.enter) + int'(lt.frame_err), 1);
      if (lt.frame_err) chk("busy_at_err", lt.busy, 0);
      if (q.size() == 0) chk("spurious", obs, 0);
      else chk("event", obs, q.pop_front());
    end
  initial begin
    tick(3);
    #1;
    chk("rst_char", lt.char, 0);
    chk("rst_cv", lt.char_valid, 0);
    chk("rst_enter", lt.enter, 0);
    chk("rst_err", lt.frame_err, 0);
    chk("rst_busy", lt.busy, 0);
    resetn = 1'b0;
    tick(5);
    exp_char(5'd1);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    chk("t1_char", lt.char, 1);
    chk("t1_drain", q.size(), 0);
    exp_char(5'd26);
    send(8'h1A);
    send(8'hF0);
    send(8'h1A);
    exp_enter();
    send(8'h5A);
    chk("t2_char", lt.char, 26);
    chk("t2_drain", q.size(), 0);
    exp_err();
    send(8'h24, 1'b1);
    exp_err();
    send(8'h24, 1'b0, 1'b0);
    chk("t3_char", lt.char, 26);
    chk("t3_drain", q.size(), 0);
    exp_char(5'd18);
    send(8'h2D);
    send(8'h2D);
    send(8'h2D);
    send(8'hF0);
    send(8'h2D);
    exp_char(5'd18);
    send(8'h2D);
    chk("t4_char", lt.char, 18);
    chk("t4_drain", q.size(), 0);
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    send(8'h16);
    chk("t5_char_kept", lt.char, 18);
    exp_char(5'd1);
    send(8'h1C);
    chk("t5_char", lt.char, 1);
    chk("t5_drain", q.size(), 0);
    exp_char(5'd5);
    send(8'h24);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
    ps2_dat = 1'b1;
    tick(2);
    #1;
    chk("t6_busy_mid", lt.busy, 1);
    exp_err();
    tick(TMO + 20);
    #1;
    chk("t6_busy_after", lt.busy, 0);
    chk("t6_tmo_drain", q.size(), 0);
    exp_char(5'd1);
    send(8'h1C);
    chk("t6_char", lt.char, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(posedge clk);
    resetn = 1'b1;
    tick(2);
    #1;
    chk("mid_rst_char", lt.char, 0);
    chk("mid_rst_cv", lt.char_valid, 0);
    chk("mid_rst_enter", lt.enter, 0);
    chk("mid_rst_err", lt.frame_err, 0);
    chk("mid_rst_busy", lt.busy, 0);
    @(posedge clk);
    resetn = 1'b0;
    tick(5);
    exp_char(5'd1);
    send(8'h1C);
    chk("post_rst_char", lt.char, 1);
    tick(20);
    chk("final_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
